// File: rtl/sc_input_pkg.sv
// Shared definitions for the player pushbutton conditioning stage: channel-state
// encoding, default timing constants and the active-low button level.
package sc_input_pkg;

  typedef enum logic [1:0] {
    ChReleased   = 2'd0,
    ChPressed    = 2'd1,
    ChRepeatWait = 2'd2
  } ch_state_e;

  // 20 ms at 50 MHz.
  localparam int unsigned DefDebounceCycles = 1000000;
  localparam int unsigned DefRepeatDelay    = 25000000;
  localparam int unsigned DefRepeatPeriod   = 10000000;

  localparam logic BtnPressed  = 1'b0;
  localparam logic BtnReleased = 1'b1;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/sc_debounce_channel.sv
// One pushbutton channel: 2-flop synchroniser, debounce counter, press/release
// state machine and, when SC_BUTTONDEBOUNCE_AUTOREPEAT_EN is defined, an
// auto-repeat pulse generator. Next-state level and pulse are exported so the
// parent can register its outputs without adding a cycle of latency.
module sc_debounce_channel
  import sc_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_btn_n,
  output logic o_level_next,
  output logic o_pulse_next
);

  localparam int unsigned     CntW   = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

  if (DEBOUNCE_CYCLES < 2) begin : g_bad_debounce
    $error("DEBOUNCE_CYCLES must be at least 2");
  end
  if (REPEAT_PERIOD < 2) begin : g_bad_period
    $error("REPEAT_PERIOD must be at least 2");
  end
  if (REPEAT_DELAY < 1) begin : g_bad_delay
    $error("REPEAT_DELAY must be at least 1");
  end

  logic            r_sync1;
  logic            r_sync2;
  logic [CntW-1:0] r_cnt;
  ch_state_e       r_state;

  logic            w_level;
  logic            w_toggle;
  logic [CntW-1:0] w_cnt_d;

  // Debounced level: 1 = released.
  assign w_level = (r_state == ChReleased);

  // Debounce counter: count consecutive disagreeing samples, toggle on the last.
  always_comb begin
    w_toggle = 1'b0;
    w_cnt_d  = '0;
    if (r_sync2 != w_level) begin
      if (r_cnt == CntMax) begin
        w_toggle = 1'b1;
      end else begin
        w_cnt_d = r_cnt + 1'b1;
      end
    end
  end

`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
  localparam int unsigned     RepMax    = max_u(REPEAT_DELAY, REPEAT_PERIOD);
  localparam int unsigned     RepW      = (RepMax > 1) ? $clog2(RepMax) : 1;
  localparam logic [RepW-1:0] DelayMax  = RepW'(REPEAT_DELAY - 1);
  localparam logic [RepW-1:0] PeriodMax = RepW'(REPEAT_PERIOD - 1);

  logic [RepW-1:0] r_rep_cnt;
  logic            w_rep_fire;

  // Repeat pulse fires when the hold timer expires and no release lands this cycle.
  always_comb begin
    w_rep_fire = 1'b0;
    if (!w_toggle) begin
      if (r_state == ChPressed) begin
        w_rep_fire = (r_rep_cnt == DelayMax);
      end else if (r_state == ChRepeatWait) begin
        w_rep_fire = (r_rep_cnt == PeriodMax);
      end
    end
  end

  assign o_pulse_next = w_rep_fire;
`else
  assign o_pulse_next = 1'b0;
`endif

  assign o_level_next = w_level ^ w_toggle;

  // Synchroniser, debounce counter and channel state machine.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sync1   <= 1'b1;
      r_sync2   <= 1'b1;
      r_cnt     <= '0;
      r_state   <= ChReleased;
`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
      r_rep_cnt <= '0;
`endif
    end else begin
      r_sync1 <= i_btn_n;
      r_sync2 <= r_sync1;
      r_cnt   <= w_cnt_d;
      unique case (r_state)
        ChReleased: begin
          if (w_toggle) r_state <= ChPressed;
`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
          r_rep_cnt <= '0;
`endif
        end
        ChPressed: begin
          if (w_toggle) begin
            r_state <= ChReleased;
          end
`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
          else if (w_rep_fire) begin
            r_state <= ChRepeatWait;
          end
          r_rep_cnt <= (w_toggle || w_rep_fire) ? '0 : r_rep_cnt + 1'b1;
`endif
        end
        ChRepeatWait: begin
          if (w_toggle) r_state <= ChReleased;
`ifdef SC_BUTTONDEBOUNCE_AUTOREPEAT_EN
          r_rep_cnt <= (w_toggle || w_rep_fire) ? '0 : r_rep_cnt + 1'b1;
`endif
        end
        default: r_state <= ChReleased;
      endcase
    end
  end

endmodule

// File: rtl/sc_player_buttondebounce.sv
// Conditions the two raw active-low player pushbuttons: per-channel debounce,
// chord lockout (both held -> both report released) and registered outputs.
// Auto-repeat pulses are compiled in when SC_BUTTONDEBOUNCE_AUTOREPEAT_EN is defined.
module sc_player_buttondebounce
  import sc_input_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DefDebounceCycles,
  parameter int unsigned REPEAT_DELAY    = DefRepeatDelay,
  parameter int unsigned REPEAT_PERIOD   = DefRepeatPeriod
) (
  input  logic SC_BUTTONDEBOUNCE_CLOCK_50,
  input  logic SC_BUTTONDEBOUNCE_RESET_InHigh,
  input  logic SC_BUTTONDEBOUNCE_LeftButton_InLow,
  input  logic SC_BUTTONDEBOUNCE_RightButton_InLow,
  output logic SC_BUTTONDEBOUNCE_LeftButton_OutLow,
  output logic SC_BUTTONDEBOUNCE_RightButton_OutLow
);

  logic w_left_level_d;
  logic w_left_pulse_d;
  logic w_right_level_d;
  logic w_right_pulse_d;
  logic w_lockout_d;
  logic r_left_out;
  logic r_right_out;

  sc_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_left (
    .i_clk        (SC_BUTTONDEBOUNCE_CLOCK_50),
    .i_rst        (SC_BUTTONDEBOUNCE_RESET_InHigh),
    .i_btn_n      (SC_BUTTONDEBOUNCE_LeftButton_InLow),
    .o_level_next (w_left_level_d),
    .o_pulse_next (w_left_pulse_d)
  );

  sc_debounce_channel #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .REPEAT_DELAY    (REPEAT_DELAY),
    .REPEAT_PERIOD   (REPEAT_PERIOD)
  ) u_right (
    .i_clk        (SC_BUTTONDEBOUNCE_CLOCK_50),
    .i_rst        (SC_BUTTONDEBOUNCE_RESET_InHigh),
    .i_btn_n      (SC_BUTTONDEBOUNCE_RightButton_InLow),
    .o_level_next (w_right_level_d),
    .o_pulse_next (w_right_pulse_d)
  );

  // Lockout uses next-state levels so a simultaneous accept never leaks a press.
  assign w_lockout_d = (w_left_level_d == BtnPressed) && (w_right_level_d == BtnPressed);

  // Output registers: level masked by lockout, plus any repeat pulse.
  always_ff @(posedge SC_BUTTONDEBOUNCE_CLOCK_50) begin
    if (SC_BUTTONDEBOUNCE_RESET_InHigh) begin
      r_left_out  <= BtnReleased;
      r_right_out <= BtnReleased;
    end else begin
      r_left_out  <= w_left_level_d | w_lockout_d | w_left_pulse_d;
      r_right_out <= w_right_level_d | w_lockout_d | w_right_pulse_d;
    end
  end

  assign SC_BUTTONDEBOUNCE_LeftButton_OutLow  = r_left_out;
  assign SC_BUTTONDEBOUNCE_RightButton_OutLow = r_right_out;

endmodule
